// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared opcode/funct values, controller state encodings and
//            datapath select constants for the multicycle MIPS-lite core.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;

   // Controller state encodings
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DCD    = 3'd1;
   localparam logic [2:0] S_EXE    = 3'd2;
   localparam logic [2:0] S_MRD    = 3'd3;
   localparam logic [2:0] S_MWR    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd7;

   // ALU operation select
   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_SUB  = 2'd1;
   localparam logic [1:0] ALU_OR   = 2'd2;

   // PC source select
   localparam logic [1:0] PCSRC_PC4 = 2'd0;
   localparam logic [1:0] PCSRC_BR  = 2'd1;
   localparam logic [1:0] PCSRC_JMP = 2'd2;

   // Register write-data select
   localparam logic [1:0] WDSEL_ALU = 2'd0;
   localparam logic [1:0] WDSEL_MEM = 2'd1;
   localparam logic [1:0] WDSEL_LUI = 2'd2;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_decode
// Purpose  : Combinational opcode/funct to instruction-class decoder.
// Revision : 1.0 - initial release
// ============================================================================
module mc_decode
   import mips_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic       is_r,
   output logic       is_addu,
   output logic       is_subu,
   output logic       is_ori,
   output logic       is_lui,
   output logic       is_lw,
   output logic       is_sw,
   output logic       is_beq,
   output logic       is_j,
   output logic       is_illegal,
   output logic       ext_sign
);

   assign is_r    = (op == OP_RTYPE);
   assign is_addu = is_r && (funct == FN_ADDU);
   assign is_subu = is_r && (funct == FN_SUBU);
   assign is_ori  = (op == OP_ORI);
   assign is_lui  = (op == OP_LUI);
   assign is_lw   = (op == OP_LW);
   assign is_sw   = (op == OP_SW);
   assign is_beq  = (op == OP_BEQ);
   assign is_j    = (op == OP_J);

   // Anything outside the supported set, including R-type with an unknown funct
   assign is_illegal = ~(is_addu | is_subu | is_ori | is_lui |
                         is_lw | is_sw | is_beq | is_j);

   // Address and branch-offset arithmetic needs the sign-extended immediate
   assign ext_sign = is_lw | is_sw | is_beq;

endmodule : mc_decode
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multicycle control FSM for the MIPS-lite core. Sequences
//            fetch/decode/execute/memory/writeback and drives all datapath
//            enables and mux selects.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl
   import mips_pkg::*;
#(
   parameter int ILLEGAL_TRAP = 0
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_wr,
   output logic [1:0] pc_src,
   output logic       ir_wr,
   output logic       mem_req,
   output logic       mem_wr,
   output logic       i_or_d,
   output logic       extcon,
   output logic       alu_src,
   output logic [1:0] alu_op,
   output logic       reg_wr,
   output logic       reg_dst,
   output logic [1:0] wd_sel,
   output logic       instr_done,
   output logic       illegal,
   output logic [2:0] state_o
);

   logic [2:0] r_state;
   logic [2:0] w_next;

   logic w_is_r, w_is_addu, w_is_subu, w_is_ori, w_is_lui;
   logic w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_illegal, w_ext_sign;
   logic w_trap;

   logic       w_pc_wr, w_ir_wr, w_mem_req, w_mem_wr, w_i_or_d, w_extcon;
   logic       w_alu_src, w_reg_wr, w_reg_dst, w_instr_done, w_illegal;
   logic [1:0] w_pc_src, w_alu_op, w_wd_sel;

   mc_decode u_decode (
      .op         (op),
      .funct      (funct),
      .is_r       (w_is_r),
      .is_addu    (w_is_addu),
      .is_subu    (w_is_subu),
      .is_ori     (w_is_ori),
      .is_lui     (w_is_lui),
      .is_lw      (w_is_lw),
      .is_sw      (w_is_sw),
      .is_beq     (w_is_beq),
      .is_j       (w_is_j),
      .is_illegal (w_is_illegal),
      .ext_sign   (w_ext_sign)
   );

   // Illegal opcodes either park the core or retire as a NOP
   generate
      if (ILLEGAL_TRAP != 0) begin : g_trap
         assign w_trap = 1'b1;
      end else begin : g_notrap
         assign w_trap = 1'b0;
      end
   endgenerate

   // State register; reset aborts any instruction in flight
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // Next-state and output decode from current state and instruction class
   always_comb begin
      w_next       = r_state;
      w_pc_wr      = 1'b0;
      w_pc_src     = PCSRC_PC4;
      w_ir_wr      = 1'b0;
      w_mem_req    = 1'b0;
      w_mem_wr     = 1'b0;
      w_i_or_d     = 1'b0;
      w_extcon     = 1'b0;
      w_alu_src    = 1'b0;
      w_alu_op     = ALU_ADD;
      w_reg_wr     = 1'b0;
      w_reg_dst    = 1'b0;
      w_wd_sel     = WDSEL_ALU;
      w_instr_done = 1'b0;
      w_illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (mem_ready) begin
               w_ir_wr  = 1'b1;
               w_pc_wr  = 1'b1;
               w_pc_src = PCSRC_PC4;
               w_next   = S_DCD;
            end
         end
         S_DCD: begin
            if (w_is_j) begin
               w_pc_wr      = 1'b1;
               w_pc_src     = PCSRC_JMP;
               w_instr_done = 1'b1;
               w_next       = S_FETCH;
            end else if (w_is_illegal) begin
               w_illegal = 1'b1;
               if (w_trap) begin
                  w_next = S_HALT;
               end else begin
                  w_instr_done = 1'b1;
                  w_next       = S_FETCH;
               end
            end else begin
               w_next = S_EXE;
            end
         end
         S_EXE: begin
            // Extender select is held from here until the instruction retires
            w_extcon = w_ext_sign;
            if (w_is_addu || w_is_subu) begin
               w_alu_src = 1'b0;
               w_alu_op  = w_is_subu ? ALU_SUB : ALU_ADD;
               w_next    = S_WB;
            end else if (w_is_ori) begin
               w_alu_src = 1'b1;
               w_alu_op  = ALU_OR;
               w_next    = S_WB;
            end else if (w_is_lui) begin
               w_next = S_WB;
            end else if (w_is_lw || w_is_sw) begin
               w_alu_src = 1'b1;
               w_alu_op  = ALU_ADD;
               w_next    = w_is_lw ? S_MRD : S_MWR;
            end else if (w_is_beq) begin
               w_alu_src    = 1'b0;
               w_alu_op     = ALU_SUB;
               w_instr_done = 1'b1;
               w_next       = S_FETCH;
               if (zero) begin
                  w_pc_wr  = 1'b1;
                  w_pc_src = PCSRC_BR;
               end
            end else begin
               w_next = S_FETCH;
            end
         end
         S_MRD: begin
            w_mem_req = 1'b1;
            w_i_or_d  = 1'b1;
            w_extcon  = 1'b1;
            w_alu_src = 1'b1;
            if (mem_ready) w_next = S_WB;
         end
         S_MWR: begin
            w_mem_req = 1'b1;
            w_mem_wr  = 1'b1;
            w_i_or_d  = 1'b1;
            w_extcon  = 1'b1;
            w_alu_src = 1'b1;
            if (mem_ready) begin
               w_instr_done = 1'b1;
               w_next       = S_FETCH;
            end
         end
         S_WB: begin
            w_reg_wr     = 1'b1;
            w_instr_done = 1'b1;
            w_extcon     = w_ext_sign;
            w_next       = S_FETCH;
            if (w_is_r) begin
               w_reg_dst = 1'b1;
               w_wd_sel  = WDSEL_ALU;
            end else if (w_is_ori) begin
               w_alu_src = 1'b1;
               w_alu_op  = ALU_OR;
               w_wd_sel  = WDSEL_ALU;
            end else if (w_is_lui) begin
               w_wd_sel = WDSEL_LUI;
            end else if (w_is_lw) begin
               w_wd_sel = WDSEL_MEM;
            end
         end
         S_HALT: begin
            w_next = S_HALT;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   // All outputs forced low while reset is asserted
   assign pc_wr      = w_pc_wr      & ~reset;
   assign pc_src     = reset ? 2'd0 : w_pc_src;
   assign ir_wr      = w_ir_wr      & ~reset;
   assign mem_req    = w_mem_req    & ~reset;
   assign mem_wr     = w_mem_wr     & ~reset;
   assign i_or_d     = w_i_or_d     & ~reset;
   assign extcon     = w_extcon     & ~reset;
   assign alu_src    = w_alu_src    & ~reset;
   assign alu_op     = reset ? 2'd0 : w_alu_op;
   assign reg_wr     = w_reg_wr     & ~reset;
   assign reg_dst    = w_reg_dst    & ~reset;
   assign wd_sel     = reset ? 2'd0 : w_wd_sel;
   assign instr_done = w_instr_done & ~reset;
   assign illegal    = w_illegal    & ~reset;
   assign state_o    = reset ? 3'd0 : r_state;

endmodule : mc_ctrl
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Self-checking bench for mc_ctrl. A transaction-level model
//            predicts, per instruction, the state trace and the number and
//            content of each datapath strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

   localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LW = 3, K_SW = 4;
   localparam int K_BEQ  = 5, K_LUI  = 6, K_J   = 7, K_ILL = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, zero, mem_ready;
   logic [5:0] op, funct;

   logic       pc_wr, ir_wr, mem_req, mem_wr, i_or_d, extcon, alu_src;
   logic       reg_wr, reg_dst, instr_done, illegal;
   logic [1:0] pc_src, alu_op, wd_sel;
   logic [2:0] state_o;

   logic       t_pc_wr, t_ir_wr, t_mem_req, t_mem_wr, t_i_or_d, t_extcon, t_alu_src;
   logic       t_reg_wr, t_reg_dst, t_instr_done, t_illegal;
   logic [1:0] t_pc_src, t_alu_op, t_wd_sel;
   logic [2:0] t_state_o;

   int n_tests = 0;
   int n_fail  = 0;

   mc_ctrl #(.ILLEGAL_TRAP(0)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr),
      .mem_req(mem_req), .mem_wr(mem_wr), .i_or_d(i_or_d), .extcon(extcon),
      .alu_src(alu_src), .alu_op(alu_op), .reg_wr(reg_wr), .reg_dst(reg_dst),
      .wd_sel(wd_sel), .instr_done(instr_done), .illegal(illegal),
      .state_o(state_o)
   );

   mc_ctrl #(.ILLEGAL_TRAP(1)) dut_trap (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_wr(t_pc_wr), .pc_src(t_pc_src), .ir_wr(t_ir_wr),
      .mem_req(t_mem_req), .mem_wr(t_mem_wr), .i_or_d(t_i_or_d), .extcon(t_extcon),
      .alu_src(t_alu_src), .alu_op(t_alu_op), .reg_wr(t_reg_wr), .reg_dst(t_reg_dst),
      .wd_sel(t_wd_sel), .instr_done(t_instr_done), .illegal(t_illegal),
      .state_o(t_state_o)
   );

   wire [19:0] all_out = {pc_wr, pc_src, ir_wr, mem_req, mem_wr, i_or_d, extcon,
                          alu_src, alu_op, reg_wr, reg_dst, wd_sel, instr_done,
                          illegal, state_o};
   wire [16:0] t_ctl   = {t_pc_wr, t_pc_src, t_ir_wr, t_mem_req, t_mem_wr, t_i_or_d,
                          t_extcon, t_alu_src, t_alu_op, t_reg_wr, t_reg_dst,
                          t_wd_sel, t_instr_done, t_illegal};

   // Pick opcode/funct encoding for an instruction kind
   task automatic pick(input int k, output logic [5:0] o, output logic [5:0] f);
      logic [5:0] bad_ops [4];
      bad_ops[0] = 6'b111111; bad_ops[1] = 6'b001000;
      bad_ops[2] = 6'b000101; bad_ops[3] = 6'b000000;
      f = 6'($urandom);
      case (k)
         K_ADDU: begin o = 6'b000000; f = 6'b100001; end
         K_SUBU: begin o = 6'b000000; f = 6'b100011; end
         K_ORI:  o = 6'b001101;
         K_LW:   o = 6'b100011;
         K_SW:   o = 6'b101011;
         K_BEQ:  o = 6'b000100;
         K_LUI:  o = 6'b001111;
         K_J:    o = 6'b000010;
         default: begin
            o = bad_ops[$urandom_range(0, 3)];
            if (o == 6'b000000) f = 6'b100000;
         end
      endcase
   endtask

   // Drive one instruction from S_FETCH and compare against the model
   task automatic run_instr(input int k, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int fw, input int mw);
      int exp_st[$];
      int mcnt = 0;
      int n_ir = 0, n_pc = 0, n_reg = 0, n_mwr = 0, n_req = 0, n_ill = 0;
      int x_pc, x_reg, x_mwr, x_req, x_ill, x_dst, x_wd, x_aop, x_asrc;
      logic x_ext;
      bit mem_kind;
      int last;
      // Model: state trace
      for (int i = 0; i <= fw; i++) exp_st.push_back(0);
      exp_st.push_back(1);
      case (k)
         K_ADDU, K_SUBU, K_ORI, K_LUI: begin exp_st.push_back(2); exp_st.push_back(5); end
         K_LW: begin
            exp_st.push_back(2);
            for (int i = 0; i <= mw; i++) exp_st.push_back(3);
            exp_st.push_back(5);
         end
         K_SW: begin
            exp_st.push_back(2);
            for (int i = 0; i <= mw; i++) exp_st.push_back(4);
         end
         K_BEQ: exp_st.push_back(2);
         default: ;
      endcase
      last     = exp_st.size() - 1;
      mem_kind = (k == K_LW || k == K_SW);
      // Model: strobe counts and select values
      x_pc   = 1 + ((k == K_J || (k == K_BEQ && z)) ? 1 : 0);
      x_reg  = (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI || k == K_LW) ? 1 : 0;
      x_mwr  = (k == K_SW) ? mw + 1 : 0;
      x_req  = fw + 1 + (mem_kind ? mw + 1 : 0);
      x_ill  = (k == K_ILL) ? 1 : 0;
      x_dst  = (k == K_ADDU || k == K_SUBU) ? 1 : 0;
      x_wd   = (k == K_LW) ? 1 : (k == K_LUI) ? 2 : 0;
      x_aop  = (k == K_SUBU || k == K_BEQ) ? 1 : (k == K_ORI) ? 2 : 0;
      x_asrc = (k == K_ORI || mem_kind) ? 1 : 0;
      x_ext  = (k == K_LW || k == K_SW || k == K_BEQ);
      op = o; funct = f;
      for (int i = 0; i <= last; i++) begin
         zero = (k == K_BEQ) ? z : 1'($urandom);
         if (exp_st[i] == 0) mem_ready = (i < fw) ? 1'b0 : 1'b1;
         else if (exp_st[i] == 3 || exp_st[i] == 4) begin
            mem_ready = (mcnt < mw) ? 1'b0 : 1'b1;
            mcnt++;
         end else mem_ready = 1'($urandom);
         @(negedge clk);
         n_tests++;
         if (state_o !== 3'(exp_st[i])) begin
            n_fail++;
            $display("FAIL state k=%0d cyc=%0d: got %0d want %0d", k, i, state_o, exp_st[i]);
         end
         n_tests++;
         if (instr_done !== (i == last)) begin
            n_fail++;
            $display("FAIL instr_done k=%0d cyc=%0d: got %b want %b", k, i, instr_done, i == last);
         end
         n_tests++;
         if (extcon !== (exp_st[i] >= 2 && x_ext)) begin
            n_fail++;
            $display("FAIL extcon k=%0d cyc=%0d: got %b want %b", k, i, extcon, exp_st[i] >= 2 && x_ext);
         end
         if (exp_st[i] == 2 && k != K_LUI) begin
            n_tests++;
            if (alu_op !== 2'(x_aop) || alu_src !== 1'(x_asrc)) begin
               n_fail++;
               $display("FAIL exe_alu k=%0d: got op=%0d src=%b want op=%0d src=%0d", k, alu_op, alu_src, x_aop, x_asrc);
            end
         end
         if (pc_wr === 1'b1) begin
            n_pc++;
            n_tests++;
            if (pc_src !== ((exp_st[i] == 0) ? 2'd0 : (k == K_J) ? 2'd2 : 2'd1)) begin
               n_fail++;
               $display("FAIL pc_src k=%0d cyc=%0d: got %0d", k, i, pc_src);
            end
         end
         if (reg_wr === 1'b1) begin
            n_reg++;
            n_tests++;
            if (reg_dst !== 1'(x_dst) || wd_sel !== 2'(x_wd) ||
                (k == K_ORI && (alu_op !== 2'd2 || alu_src !== 1'b1))) begin
               n_fail++;
               $display("FAIL wb_sel k=%0d: got dst=%b wd=%0d aop=%0d want dst=%0d wd=%0d", k, reg_dst, wd_sel, alu_op, x_dst, x_wd);
            end
         end
         if (mem_req === 1'b1) begin
            n_req++;
            n_tests++;
            if (i_or_d !== (exp_st[i] != 0)) begin
               n_fail++;
               $display("FAIL i_or_d k=%0d cyc=%0d: got %b", k, i, i_or_d);
            end
         end
         if (ir_wr === 1'b1)   n_ir++;
         if (mem_wr === 1'b1)  n_mwr++;
         if (illegal === 1'b1) n_ill++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (n_ir != 1 || n_pc != x_pc || n_reg != x_reg || n_mwr != x_mwr ||
          n_req != x_req || n_ill != x_ill) begin
         n_fail++;
         $display("FAIL counts k=%0d: got ir=%0d pc=%0d reg=%0d mwr=%0d req=%0d ill=%0d want 1/%0d/%0d/%0d/%0d/%0d",
                  k, n_ir, n_pc, n_reg, n_mwr, n_req, n_ill, x_pc, x_reg, x_mwr, x_req, x_ill);
      end
   endtask

   // Hold reset for one cycle and check every output is quiet
   task automatic test_reset();
      reset = 1'b1;
      mem_ready = 1'($urandom); zero = 1'($urandom);
      op = 6'($urandom); funct = 6'($urandom);
      @(negedge clk);
      n_tests++;
      if (all_out !== 20'd0 || t_ctl !== 17'd0 || t_state_o !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h / %h / %0d want 0", all_out, t_ctl, t_state_o);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_addu();
      logic [5:0] o, f;
      test_reset();
      pick(K_ADDU, o, f);
      run_instr(K_ADDU, o, f, 1'b0, 0, 0);
   endtask

   task automatic test_lw_wait();
      logic [5:0] o, f;
      test_reset();
      pick(K_LW, o, f);
      run_instr(K_LW, o, f, 1'b0, 0, 3);
   endtask

   task automatic test_beq();
      logic [5:0] o, f;
      test_reset();
      pick(K_BEQ, o, f);
      run_instr(K_BEQ, o, f, 1'b1, 0, 0);
      run_instr(K_BEQ, o, f, 1'b0, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [5:0] o, f;
      test_reset();
      pick(K_ORI, o, f);
      run_instr(K_ORI, o, f, 1'b0, 0, 0);
      pick(K_LUI, o, f);
      run_instr(K_LUI, o, f, 1'b0, 0, 0);
   endtask

   task automatic test_illegal();
      test_reset();
      run_instr(K_ILL, 6'b111111, 6'd0, 1'b0, 0, 0);
      // Trap instance parked in S_HALT: state 7, no enables, until reset
      for (int i = 0; i < 6; i++) begin
         mem_ready = 1'($urandom); zero = 1'($urandom);
         @(negedge clk);
         n_tests++;
         if (t_state_o !== 3'd7 || t_ctl !== 17'd0) begin
            n_fail++;
            $display("FAIL trap_halt cyc=%0d: got state=%0d ctl=%h want 7/0", i, t_state_o, t_ctl);
         end
         @(posedge clk); #1;
      end
      test_reset();
      @(negedge clk);
      n_tests++;
      if (t_state_o !== 3'd0) begin
         n_fail++;
         $display("FAIL trap_exit: got %0d want 0", t_state_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_sw();
      int seq [5];
      seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 4; seq[4] = 4;
      test_reset();
      op = 6'b101011; funct = 6'd0;
      for (int i = 0; i < 5; i++) begin
         mem_ready = (i == 0) ? 1'b1 : 1'b0;
         reset     = (i == 4) ? 1'b1 : 1'b0;
         @(negedge clk);
         n_tests++;
         if (i < 4 && state_o !== 3'(seq[i])) begin
            n_fail++;
            $display("FAIL sw_abort_state cyc=%0d: got %0d want %0d", i, state_o, seq[i]);
         end else if (i == 4 && all_out !== 20'd0) begin
            n_fail++;
            $display("FAIL sw_abort_outputs: got %h want 0", all_out);
         end
         @(posedge clk); #1;
      end
      reset = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (state_o !== 3'd0 || instr_done !== 1'b0 || mem_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_abort_after: got state=%0d done=%b mem_wr=%b want 0/0/0", state_o, instr_done, mem_wr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [5:0] o, f;
      int k;
      test_reset();
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 8);
         pick(k, o, f);
         run_instr(k, o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
      end
   endtask

   initial begin
      reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_addu();
      test_lw_wait();
      test_beq();
      test_back_to_back();
      test_illegal();
      test_reset_mid_sw();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mc_ctrl
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the MIPS-lite core.
- Sequences IR, PC, register file, ALU, data memory and the immediate extender (drives its `extcon` select) through the FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps.
- Takes opcode/funct from the IR and the ALU zero flag, and emits all datapath enables and muxes.
- Waits on a memory ready handshake and reports instruction completion.

Parameters:
- ILLEGAL_TRAP, 0, 1 = park in S_HALT on an unsupported opcode; 0 = treat it as a NOP.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26]; valid from S_DCD onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, valid in S_EXE.
- mem_ready  in  1  memory access complete this cycle.
- pc_wr  out  1  PC write enable.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- ir_wr  out  1  IR load.
- mem_req  out  1  memory access request.
- mem_wr  out  1  data memory write; only meaningful with mem_req.
- i_or_d  out  1  0 = instruction address, 1 = ALU result address.
- extcon  out  1  extender select: 1 = sign-extend, 0 = zero-extend.
- alu_src  out  1  0 = rt, 1 = extended immediate.
- alu_op  out  2  0 = add, 1 = sub, 2 = or.
- reg_wr  out  1  register file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- wd_sel  out  2  0 = ALU, 1 = memory data, 2 = {imm16, 16'b0}.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  one-cycle pulse in S_DCD for an unsupported opcode.
- state_o  out  3  current state, for debug.

Behaviour:
- States (3-bit): S_FETCH = 0, S_DCD = 1, S_EXE = 2, S_MRD = 3, S_MWR = 4, S_WB = 5, S_HALT = 7.
- Reset: state <= S_FETCH. While reset is high, every output is 0.
- Outputs are decoded combinationally from the state register and op/funct (Moore/Mealy mix). Any output not named for a state is 0.
- Supported instructions:
  - addu: op 000000, funct 100001.
  - subu: op 000000, funct 100011.
  - ori: op 001101.
  - lw: op 100011.
  - sw: op 101011.
  - beq: op 000100.
  - lui: op 001111.
  - j: op 000010.
  - An R-type op with any other funct is illegal.
- S_FETCH:
  - Drive mem_req = 1, i_or_d = 0.
  - If mem_ready: ir_wr = 1, pc_wr = 1, pc_src = 0, go to S_DCD.
  - Otherwise hold; no enables other than mem_req.
- S_DCD:
  - j: pc_wr = 1, pc_src = 2, instr_done = 1, go to S_FETCH.
  - Illegal op: illegal = 1. ILLEGAL_TRAP = 0: instr_done = 1, go to S_FETCH. ILLEGAL_TRAP = 1: go to S_HALT.
  - All others: go to S_EXE.
- S_EXE:
  - addu/subu: alu_src = 0, alu_op = add/sub, go to S_WB.
  - ori: alu_src = 1, extcon = 0, alu_op = or, go to S_WB.
  - lui: go to S_WB.
  - lw/sw: alu_src = 1, extcon = 1, alu_op = add, go to S_MRD or S_MWR.
  - beq: alu_src = 0, alu_op = sub, extcon = 1. If zero: pc_wr = 1, pc_src = 1. Either way instr_done = 1, go to S_FETCH.
- extcon is 1 for lw/sw/beq and 0 otherwise. It is held stable in every state from S_EXE through S_WB for the current instruction.
- S_MRD:
  - mem_req = 1, i_or_d = 1, extcon = 1, alu_src = 1.
  - On mem_ready go to S_WB; otherwise wait indefinitely.
- S_MWR:
  - mem_req = 1, mem_wr = 1, i_or_d = 1, extcon = 1, alu_src = 1.
  - On mem_ready: instr_done = 1, go to S_FETCH.
- S_WB:
  - reg_wr = 1, instr_done = 1, go to S_FETCH.
  - R-type: reg_dst = 1, wd_sel = 0.
  - ori: reg_dst = 0, wd_sel = 0, extcon = 0, alu_src = 1, alu_op = or.
  - lui: reg_dst = 0, wd_sel = 2.
  - lw: reg_dst = 0, wd_sel = 1.
- S_HALT: all outputs 0; exited only by reset.
- Unused state encodings (6) go to S_FETCH on the next edge.
- Reset mid-instruction (including mid-memory-wait): abort, no write enables that cycle, S_FETCH next cycle.
- Cycle counts with mem_ready tied to 1:
  - j, illegal NOP: 2.
  - beq: 3.
  - sw: 4.
  - R-type, ori, lui: 4.
  - lw: 5.

Decomposition:
- Shared package `mips_pkg`:
  - Opcode and funct localparams.
  - State encodings.
  - ALU_ADD/SUB/OR, PCSRC_*, WDSEL_* constants.
- One natural sub-module, `mc_decode`:
  - Combinational op/funct to instruction class: is_r, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_illegal.
  - Also provides ext_sign = is_lw | is_sw | is_beq.

Test Plan:
- Reset, mem_ready = 1, op = addu: state sequence 0, 1, 2, 5, 0. reg_wr = 1 and reg_dst = 1 only in cycle 4; instr_done pulses in cycle 4; all outputs 0 during reset.
- op = lw, mem_ready low for 3 cycles in S_MRD: 5 + 3 = 8 cycles total. extcon = 1 from S_EXE through S_WB. wd_sel = 1 in S_WB; reg_wr asserted exactly once.
- op = beq: with zero = 1, pc_wr = 1 and pc_src = 1 in S_EXE, 3 cycles. Repeat with zero = 0: pc_wr = 0 in S_EXE, instr_done still pulses.
- op = ori then lui back to back: extcon = 0 in every cycle. ori gives alu_op = 2 in S_EXE and S_WB; lui gives wd_sel = 2 in S_WB; 8 cycles total.
- op = 111111: ILLEGAL_TRAP = 0 gives illegal and instr_done together, back to S_FETCH. ILLEGAL_TRAP = 1 gives state 7 held with no enables until reset.
- sw with mem_ready = 0; assert reset in the 2nd S_MWR cycle: mem_wr = 0 during reset, state 0 next cycle, no instr_done pulse.
